// File: rtl/processor_selftest_checker.sv
// Self-test sequencer: pulses the processor reset, runs it for CYCLE_LIMIT cycles,
// freezes it, then scans an expected-value table against the regfile debug port.
module processor_selftest_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CYCLE_LIMIT    = 10,
  parameter int NUM_CHECKS     = 5,
  parameter int IDX_WIDTH      = 8,
  parameter int ERR_WIDTH      = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [IDX_WIDTH-1:0]      chk_index,
  input  logic [REG_ADDR_WIDTH-1:0] chk_reg,
  input  logic [DATA_WIDTH-1:0]     chk_value,
  output logic                      proc_reset,
  output logic                      proc_run,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0]     rf_read_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_WIDTH-1:0]      error_count,
  output logic                      fail_valid,
  output logic [REG_ADDR_WIDTH-1:0] fail_reg,
  output logic [DATA_WIDTH-1:0]     fail_expected,
  output logic [DATA_WIDTH-1:0]     fail_read,
  output logic [2:0]                dbg_state
);

  localparam int CNT_W = $clog2(CYCLE_LIMIT + 1);

  // dbg_state carries the raw encoding below; IDLE is 0.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRST = 3'd1,
    S_RUN  = 3'd2,
    S_ADDR = 3'd3,
    S_READ = 3'd4,
    S_CMP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CNT_W-1:0]          cyc_cnt;
  logic [REG_ADDR_WIDTH-1:0] exp_reg;
  logic [DATA_WIDTH-1:0]     exp_val;
  logic                      mismatch;
  logic                      last_chk;
  logic                      run_last;

  assign mismatch = (rf_read_data != exp_val);
  assign last_chk = (chk_index == IDX_WIDTH'(NUM_CHECKS - 1));
  assign run_last = (cyc_cnt == CNT_W'(CYCLE_LIMIT - 1));
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // start is a level request with no handshake: it is honoured only while
  // busy is low (IDLE or DONE) and silently dropped in every other state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_PRST;
      S_PRST:  state_next = S_RUN;
      S_RUN:   if (run_last) state_next = S_ADDR;
      S_ADDR:  state_next = S_READ;
      S_READ:  state_next = S_CMP;
      S_CMP:   state_next = last_chk ? S_DONE : S_ADDR;
      S_DONE:  if (start) state_next = S_PRST;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    proc_reset = (state == S_IDLE) || (state == S_PRST);
    proc_run   = (state == S_RUN);
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
    pass       = done && (error_count == '0);
    fail_valid = (state == S_CMP) && mismatch;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt       <= '0;
      chk_index     <= '0;
      exp_reg       <= '0;
      exp_val       <= '0;
      rf_read_addr  <= '0;
      error_count   <= '0;
      fail_reg      <= '0;
      fail_expected <= '0;
      fail_read     <= '0;
    end else begin
      case (state)
        S_PRST: begin
          cyc_cnt       <= '0;
          chk_index     <= '0;
          error_count   <= '0;
          fail_reg      <= '0;
          fail_expected <= '0;
          fail_read     <= '0;
        end
        S_RUN: cyc_cnt <= cyc_cnt + 1'b1;
        S_ADDR: begin
          exp_reg      <= chk_reg;
          exp_val      <= chk_value;
          rf_read_addr <= chk_reg;
        end
        S_CMP: begin
          if (mismatch) begin
            fail_reg      <= exp_reg;
            fail_expected <= exp_val;
            fail_read     <= rf_read_data;
            if (error_count != '1) error_count <= error_count + 1'b1;
          end
          // Index parks on the last entry so it never leaves the table.
          if (!last_chk) chk_index <= chk_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_selftest_checker.sv
// Bench for processor_selftest_checker: vector table, random tables against a
// mismatch-counting model, mid-test reset, saturation and minimal-size instances.
module tb_processor_selftest_checker;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // main instance (defaults)
  logic        start = 1'b0;
  logic [7:0]  m_idx;
  logic [4:0]  m_chk_reg;
  logic [31:0] m_chk_val;
  logic        m_prst, m_run, m_busy, m_done, m_pass, m_fv;
  logic [4:0]  m_rd_addr, m_freg;
  logic [31:0] m_rd_data, m_fexp, m_fread;
  logic [7:0]  m_err;
  logic [2:0]  m_dbg;

  logic [4:0]  tab_reg[5];
  logic [31:0] tab_val[5];
  logic [31:0] regs[32];

  always_comb begin
    m_chk_reg = '0;
    m_chk_val = '0;
    if (m_idx < 8'd5) begin
      m_chk_reg = tab_reg[m_idx[2:0]];
      m_chk_val = tab_val[m_idx[2:0]];
    end
  end

  always @(posedge clock) m_rd_data <= regs[m_rd_addr];

  processor_selftest_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .chk_index(m_idx), .chk_reg(m_chk_reg), .chk_value(m_chk_val),
    .proc_reset(m_prst), .proc_run(m_run),
    .rf_read_addr(m_rd_addr), .rf_read_data(m_rd_data),
    .busy(m_busy), .done(m_done), .pass(m_pass), .error_count(m_err),
    .fail_valid(m_fv), .fail_reg(m_freg), .fail_expected(m_fexp), .fail_read(m_fread),
    .dbg_state(m_dbg)
  );

  // saturation instance: entry i checks r(i+1) against i+1, regfile reads 0
  logic        s_start = 1'b0;
  logic [7:0]  s_idx;
  logic [4:0]  s_chk_reg, s_rd_addr, s_freg;
  logic [31:0] s_chk_val, s_fexp, s_fread;
  logic        s_prst, s_run, s_busy, s_done, s_pass, s_fv;
  logic [1:0]  s_err;
  logic [2:0]  s_dbg;
  logic [31:0] s_rd_data;
  assign s_chk_reg = s_idx[4:0] + 5'd1;
  assign s_chk_val = {24'd0, s_idx} + 32'd1;
  always @(posedge clock) s_rd_data <= (s_rd_addr == 5'd31) ? 32'hFFFF_FFFF : 32'd0;

  processor_selftest_checker #(.ERR_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .start(s_start),
    .chk_index(s_idx), .chk_reg(s_chk_reg), .chk_value(s_chk_val),
    .proc_reset(s_prst), .proc_run(s_run),
    .rf_read_addr(s_rd_addr), .rf_read_data(s_rd_data),
    .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_err),
    .fail_valid(s_fv), .fail_reg(s_freg), .fail_expected(s_fexp), .fail_read(s_fread),
    .dbg_state(s_dbg)
  );

  // minimal instance: one check, r3 expected 0xA5
  logic        n_start = 1'b0;
  logic [7:0]  n_idx;
  logic [4:0]  n_rd_addr, n_freg;
  logic [31:0] n_fexp, n_fread, n_rd_data;
  logic        n_prst, n_run, n_busy, n_done, n_pass, n_fv;
  logic [7:0]  n_err;
  logic [2:0]  n_dbg;
  always @(posedge clock) n_rd_data <= (n_rd_addr == 5'd3) ? 32'hA5 : 32'd0;

  processor_selftest_checker #(.CYCLE_LIMIT(1), .NUM_CHECKS(1)) dut_min (
    .clock(clock), .reset(reset), .start(n_start),
    .chk_index(n_idx), .chk_reg(5'd3), .chk_value(32'hA5),
    .proc_reset(n_prst), .proc_run(n_run),
    .rf_read_addr(n_rd_addr), .rf_read_data(n_rd_data),
    .busy(n_busy), .done(n_done), .pass(n_pass), .error_count(n_err),
    .fail_valid(n_fv), .fail_reg(n_freg), .fail_expected(n_fexp), .fail_read(n_fread),
    .dbg_state(n_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Packed fields list entry 4 first, entry 0 last.
  typedef struct {
    logic [4:0][4:0]  treg;
    logic [4:0][31:0] tval;
    logic             load;
    logic             ovr;
    logic [4:0]       ovr_a;
    logic [31:0]      ovr_d;
    int               pa;
    int               pb;
    int               exp_err;
    logic [4:0]       exp_freg;
    logic [31:0]      exp_fexp;
    logic [31:0]      exp_fread;
    int               exp_fcyc;
  } vec_t;

  vec_t vecs[5];

  task automatic apply_vec(input vec_t v);
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tab_reg[i] = v.treg[i];
      tab_val[i] = v.tval[i];
    end
    if (v.load) for (int i = 0; i < 5; i++) regs[tab_reg[i]] = tab_val[i];
    if (v.ovr) regs[v.ovr_a] = v.ovr_d;
  endtask

  // Starts a test from a negedge and watches the main instance until done.
  // Cycle 1 begins at the edge that samples start.
  task automatic run_main(input int pa, input int pb, output int lat, output int runs,
                          output int first_run, output int fails, output int fcyc,
                          output int prst_bad);
    lat = -1; runs = 0; first_run = -1; fails = 0; fcyc = 0; prst_bad = 0;
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clock);
      @(negedge clock);
      start = (c == pa) || (c == pb);
      if ((c == 1) != m_prst) prst_bad++;
      if (m_run) begin
        runs++;
        if (first_run < 0) first_run = c;
      end
      if (m_fv) begin
        fails++;
        fcyc = c;
      end
      if (m_done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input int runs, input int first_run,
                              input int fails, input int fcyc, input int prst_bad,
                              input int exp_err, input logic [4:0] exp_freg,
                              input logic [31:0] exp_fexp, input logic [31:0] exp_fread,
                              input int exp_fcyc);
    check({tag, " latency"}, lat, 27);
    check({tag, " run_cycles"}, runs, 10);
    check({tag, " first_run"}, first_run, 2);
    check({tag, " proc_reset_seq"}, prst_bad, 0);
    check({tag, " fail_pulses"}, fails, exp_err);
    check({tag, " last_fail_cycle"}, fcyc, exp_fcyc);
    check({tag, " error_count"}, m_err, exp_err);
    check({tag, " pass"}, m_pass, exp_err == 0);
    check({tag, " busy_done"}, {m_busy, m_done}, 2'b01);
    check({tag, " fail_reg"}, m_freg, exp_freg);
    check({tag, " fail_expected"}, m_fexp, exp_fexp);
    check({tag, " fail_read"}, m_fread, exp_fread);
    check({tag, " chk_index"}, m_idx, 4);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " proc_reset"}, m_prst, 1);
    check({tag, " quiet_outputs"}, {m_run, m_busy, m_done, m_pass, m_fv}, 0);
    check({tag, " error_count"}, m_err, 0);
    check({tag, " chk_index"}, m_idx, 0);
    check({tag, " rf_read_addr"}, m_rd_addr, 0);
    check({tag, " fail_fields"}, {m_freg, m_fexp, m_fread}, 0);
    check({tag, " dbg_state"}, m_dbg, 0);
  endtask

  int lat, runs, first_run, fails, fcyc, prst_bad;

  initial begin
    vec_t v;
    for (int i = 0; i < 5; i++) begin
      tab_reg[i] = '0;
      tab_val[i] = '0;
    end
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;

    // {1:4,2:0,3:0,4:4,5:5}, regfile agrees
    vecs[0] = '{treg: {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, tval: {32'd5, 32'd4, 32'd0, 32'd0, 32'd4},
                load: 1, ovr: 0, ovr_a: 0, ovr_d: 0, pa: -1, pb: -1,
                exp_err: 0, exp_freg: 0, exp_fexp: 0, exp_fread: 0, exp_fcyc: 0};
    // same table, r4 reads 3: fails in the 4th compare (cycle 14+3*3)
    vecs[1] = vecs[0];
    vecs[1].ovr = 1; vecs[1].ovr_a = 5'd4; vecs[1].ovr_d = 32'd3;
    vecs[1].exp_err = 1; vecs[1].exp_freg = 5'd4; vecs[1].exp_fexp = 32'd4;
    vecs[1].exp_fread = 32'd3; vecs[1].exp_fcyc = 23;
    // r0 and duplicate r6 entries {0:7,6:1,6:1,0:0,7:9}; r0 ends at 0
    vecs[2] = '{treg: {5'd7, 5'd0, 5'd6, 5'd6, 5'd0}, tval: {32'd9, 32'd0, 32'd1, 32'd1, 32'd7},
                load: 1, ovr: 0, ovr_a: 0, ovr_d: 0, pa: -1, pb: -1,
                exp_err: 1, exp_freg: 5'd0, exp_fexp: 32'd7, exp_fread: 32'd0, exp_fcyc: 14};
    // every entry mismatches against an all-zero regfile
    vecs[3] = '{treg: {5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, tval: {32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                load: 0, ovr: 0, ovr_a: 0, ovr_d: 0, pa: -1, pb: -1,
                exp_err: 5, exp_freg: 5'd5, exp_fexp: 32'd5, exp_fread: 32'd0, exp_fcyc: 26};
    // clean re-run after a failed one, start poked during RUN (4) and ADDR (12)
    vecs[4] = vecs[0];
    vecs[4].pa = 4; vecs[4].pb = 12;

    repeat (3) @(negedge clock);
    check_reset_state("reset");
    check("reset sat_dbg", {s_dbg, n_dbg, s_prst, n_prst}, 8'b0000_0011);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle holds proc_reset", {m_prst, m_busy}, 2'b10);

    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      apply_vec(v);
      run_main(v.pa, v.pb, lat, runs, first_run, fails, fcyc, prst_bad);
      check_result($sformatf("vec%0d", k), lat, runs, first_run, fails, fcyc, prst_bad,
                   v.exp_err, v.exp_freg, v.exp_fexp, v.exp_fread, v.exp_fcyc);
      repeat (2) @(negedge clock);
      check($sformatf("vec%0d done_held", k), {m_done, m_run, m_prst}, 3'b100);
    end

    // random tables and regfile contents against a mismatch-counting model
    for (int t = 0; t < 12; t++) begin
      int e_err, e_last;
      for (int r = 0; r < 32; r++) regs[r] = (r < 8) ? 32'($urandom_range(0, 3)) : 32'd0;
      for (int i = 0; i < 5; i++) begin
        tab_reg[i] = 5'($urandom_range(0, 7));
        tab_val[i] = 32'($urandom_range(0, 3));
      end
      e_err = 0;
      e_last = -1;
      for (int i = 0; i < 5; i++)
        if (regs[tab_reg[i]] != tab_val[i]) begin
          e_err++;
          e_last = i;
        end
      run_main(-1, -1, lat, runs, first_run, fails, fcyc, prst_bad);
      check_result($sformatf("rand%0d", t), lat, runs, first_run, fails, fcyc, prst_bad, e_err,
                   (e_last < 0) ? 5'd0 : tab_reg[e_last],
                   (e_last < 0) ? 32'd0 : tab_val[e_last],
                   (e_last < 0) ? 32'd0 : regs[tab_reg[e_last]],
                   (e_last < 0) ? 0 : 14 + 3 * e_last);
      @(negedge clock);
    end

    // reset during check 3 (READ at cycle 19) of an all-mismatch run
    apply_vec(vecs[3]);
    start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
    end
    check("midreset errors_before", m_err, 2);
    #1 reset = 1'b1;
    #1 check_reset_state("midreset async");
    @(negedge clock);
    check("midreset no_fail_pulse", {m_fv, m_err}, 0);
    reset = 1'b0;
    @(negedge clock);
    apply_vec(vecs[0]);
    run_main(-1, -1, lat, runs, first_run, fails, fcyc, prst_bad);
    check_result("after_reset", lat, runs, first_run, fails, fcyc, prst_bad, 0, 0, 0, 0, 0);

    // saturating counter and the one-check/one-cycle instance, run together
    begin
      int s_lat, s_fails, n_lat, n_runs;
      s_lat = -1; s_fails = 0; n_lat = -1; n_runs = 0;
      s_start = 1'b1;
      n_start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clock);
        @(negedge clock);
        s_start = 1'b0;
        n_start = 1'b0;
        if (s_fv && s_lat < 0) s_fails++;
        if (s_done && s_lat < 0) s_lat = c;
        if (n_run && n_lat < 0) n_runs++;
        if (n_done && n_lat < 0) n_lat = c;
        if (s_lat >= 0 && n_lat >= 0) break;
      end
      check("sat latency", s_lat, 27);
      check("sat fail_pulses", s_fails, 5);
      check("sat error_count", s_err, 3);
      check("sat pass", s_pass, 0);
      check("sat fail_fields", {s_freg, s_fexp, s_fread}, {5'd5, 32'd5, 32'd0});
      check("sat chk_index", s_idx, 4);
      check("min latency", n_lat, 6);
      check("min run_cycles", n_runs, 1);
      check("min result", {n_pass, n_err, n_fv, n_busy}, {1'b1, 8'd0, 1'b0, 1'b0});
      check("min chk_index", n_idx, 0);
      check("min fail_fields", {n_freg, n_fexp, n_fread, n_rd_addr}, {69'd0, 5'd3});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
